wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Round-robin Wishbone bus arbiter with a per-transfer watchdog. It sits between N bus masters and the shared slave-side bus.
- Grants ownership to one master at a time and gates that master's cyc/stb onto the bus.
- Routes the ack/err returned by the slave-side decoder back to the owner only.
- Aborts a transfer with err when the slave does not respond within TIMEOUT_CYCLES.

Parameters:
- MASTERS_NUM, 2, number of requesting masters (>=2).
- TIMEOUT_CYCLES, 256, consecutive stb-high cycles without ack/err before abort (>=2).
- Derived: GRANT_W = $clog2(MASTERS_NUM); TMR_W = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge
- rst_i  in  1  reset, asynchronous, active-high
- m_cyc_i  in  MASTERS_NUM  per-master cycle request
- m_stb_i  in  MASTERS_NUM  per-master strobe
- s_ack_i  in  1  ack from the currently decoded slave
- s_err_i  in  1  err from the currently decoded slave
- s_cyc_o  out  1  gated cyc to the slave side
- s_stb_o  out  1  gated stb to the slave side
- m_ack_o  out  MASTERS_NUM  ack to the owning master only
- m_err_o  out  MASTERS_NUM  err to the owning master only (slave err or timeout)
- grant_o  out  GRANT_W  index of the current owner; drives the address/data muxes
- grant_valid_o  out  1  high while a master owns the bus
- timeout_o  out  1  one-cycle pulse on each watchdog abort
- timeout_master_o  out  GRANT_W  index of the master aborted most recently
- timeout_count_o  out  8  saturating count of aborts since reset

Behaviour:
- Reset (async, any state, mid-transfer included):
  - state=IDLE; grant_o, ptr, timer, timeout_master_o and timeout_count_o all 0.
  - All outputs low/0 on assertion, without waiting for a clock edge.
- States: IDLE, GRANTED, ABORT_ERR, ABORT_WAIT.
- IDLE:
  - grant_valid_o=0; s_cyc_o=s_stb_o=0; m_ack_o=m_err_o=0.
  - If |m_cyc_i, scan indices ptr, ptr+1, ... mod MASTERS_NUM. The first set bit is registered into grant_o, and the state moves to GRANTED at the next edge.
  - Request-to-grant latency: 1 cycle.
- GRANTED:
  - grant_valid_o=1.
  - s_cyc_o=m_cyc_i[grant_o] and s_stb_o=m_stb_i[grant_o], both combinational.
  - m_ack_o = s_ack_i<<grant_o and m_err_o = s_err_i<<grant_o, both combinational, and only while m_stb_i[grant_o]=1. Otherwise ack/err are ignored and outputs are 0.
  - Other masters' cyc/stb have no effect.
- Timer (GRANTED only):
  - Cleared when stb is low or when ack|err is high.
  - Otherwise incremented each cycle.
  - If timer==TIMEOUT_CYCLES-1, stb is high and ack|err is low, go to ABORT_ERR.
  - Ack or err in that same limit cycle wins: no abort, timer clears.
  - Result: with a silent slave, abort is entered after exactly TIMEOUT_CYCLES stb-high cycles.
- GRANTED -> IDLE when m_cyc_i[grant_o]=0; ptr <= (grant_o+1) mod MASTERS_NUM.
  - There is always at least one IDLE dead cycle between successive owners.
  - The same master may be regranted only if no other master requests.
- ABORT_ERR (exactly 1 cycle):
  - s_cyc_o=s_stb_o=0.
  - m_err_o[grant_o]=1, regardless of stb.
  - timeout_o=1.
  - timeout_master_o<=grant_o.
  - timeout_count_o increments and saturates at 255.
  - Next state: ABORT_WAIT.
- ABORT_WAIT:
  - s_cyc_o=s_stb_o=0; ack/err suppressed; grant_valid_o=1.
  - Held until m_cyc_i[grant_o]=0, then IDLE with ptr=grant_o+1.
  - Late slave ack/err in this state is dropped.
- Back-to-back transfers by the owner (cyc held, stb toggling) stay in GRANTED; the timer restarts on each transfer.
- grant_o holds its value in IDLE. It is only meaningful when grant_valid_o=1.

Test Plan:
- Reset/idle: assert rst_i mid-GRANTED with no clock edge.
  - -> all outputs 0 immediately; state IDLE after release; first grant goes to master 0.
- Round-robin fairness (MASTERS_NUM=2): m_cyc_i=2'b11 held; each master does one single transfer, ack after 2 cycles, then drops cyc for 1 cycle.
  - -> grant sequence 0,1,0,1; one IDLE cycle between owners; m_ack_o only on the owner's bit.
- Single requester: only master 1 requests, 3 transfers separated by cyc drops.
  - -> grant_o=1 every time; grant 1 cycle after cyc rise.
- Timeout (TIMEOUT_CYCLES=4): master 0 holds stb, slave silent.
  - -> ABORT_ERR after 4 stb-high cycles; m_err_o=2'b01 and timeout_o for 1 cycle; s_cyc_o=0; timeout_count_o=1; grant held until m_cyc_i[0] falls.
- Race at limit (TIMEOUT_CYCLES=4): s_ack_i arrives in the 4th stb cycle.
  - -> m_ack_o[0]=1; no abort; timeout_count_o unchanged.
- Counter saturation: force 260 timeouts.
  - -> timeout_count_o=255; late ack during ABORT_WAIT is never forwarded.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter for MASTERS_NUM masters with a
// per-transfer watchdog that aborts silent slaves with an err to the owner.
module wb_arbiter #(
    parameter int MASTERS_NUM    = 2,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int GRANT_W = $clog2(MASTERS_NUM),
    localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [MASTERS_NUM-1:0] m_cyc_i,
    input  logic [MASTERS_NUM-1:0] m_stb_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic [MASTERS_NUM-1:0] m_ack_o,
    output logic [MASTERS_NUM-1:0] m_err_o,
    output logic [GRANT_W-1:0]     grant_o,
    output logic                   grant_valid_o,
    output logic                   timeout_o,
    output logic [GRANT_W-1:0]     timeout_master_o,
    output logic [7:0]             timeout_count_o
);

    typedef enum logic [1:0] {IDLE, GRANTED, ABORT_ERR, ABORT_WAIT} state_e;

    state_e             state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] ptr_q, ptr_d;
    logic [GRANT_W-1:0] tmo_master_q, tmo_master_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         tmo_count_q, tmo_count_d;

    logic               own_cyc;
    logic               own_stb;
    logic               own_rsp;
    logic [GRANT_W-1:0] next_owner;
    logic [GRANT_W-1:0] scan_pick;
    logic               scan_hit;

    // Rotating index: base+offs folded back into 0..MASTERS_NUM-1.
    function automatic logic [GRANT_W-1:0] wrap_idx(input logic [GRANT_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= MASTERS_NUM) begin
            sum = sum - MASTERS_NUM;
        end
        return GRANT_W'(sum);
    endfunction

    assign own_cyc    = m_cyc_i[grant_q];
    assign own_stb    = m_stb_i[grant_q];
    assign own_rsp    = s_ack_i | s_err_i;
    assign next_owner = (grant_q == GRANT_W'(MASTERS_NUM - 1)) ? '0 : grant_q + GRANT_W'(1);

    // Pick the first requester at or after the round-robin pointer.
    always_comb begin
        scan_hit  = 1'b0;
        scan_pick = '0;
        for (int i = 0; i < MASTERS_NUM; i++) begin
            if (!scan_hit && m_cyc_i[wrap_idx(ptr_q, i)]) begin
                scan_hit  = 1'b1;
                scan_pick = wrap_idx(ptr_q, i);
            end
        end
    end

    // Next-state logic: ownership transitions, watchdog timer and abort bookkeeping.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        timer_d      = timer_q;
        tmo_master_d = tmo_master_q;
        tmo_count_d  = tmo_count_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (scan_hit) begin
                    grant_d = scan_pick;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    ptr_d   = next_owner;
                    timer_d = '0;
                end else if (!own_stb || own_rsp) begin
                    timer_d = '0;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = ABORT_ERR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ABORT_ERR: begin
                state_d      = ABORT_WAIT;
                tmo_master_d = grant_q;
                if (tmo_count_q != 8'hFF) begin
                    tmo_count_d = tmo_count_q + 8'd1;
                end
            end
            ABORT_WAIT: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    ptr_d   = next_owner;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: gate the owner onto the bus and route responses back to it only.
    always_comb begin
        s_cyc_o       = 1'b0;
        s_stb_o       = 1'b0;
        m_ack_o       = '0;
        m_err_o       = '0;
        grant_valid_o = 1'b0;
        timeout_o     = 1'b0;
        case (state_q)
            GRANTED: begin
                grant_valid_o = 1'b1;
                s_cyc_o       = own_cyc;
                s_stb_o       = own_stb;
                if (own_stb) begin
                    m_ack_o[grant_q] = s_ack_i;
                    m_err_o[grant_q] = s_err_i;
                end
            end
            ABORT_ERR: begin
                grant_valid_o    = 1'b1;
                m_err_o[grant_q] = 1'b1;
                timeout_o        = 1'b1;
            end
            ABORT_WAIT: begin
                grant_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            timer_q      <= '0;
            tmo_master_q <= '0;
            tmo_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
            tmo_master_q <= tmo_master_d;
            tmo_count_q  <= tmo_count_d;
        end
    end

    assign grant_o          = grant_q;
    assign timeout_master_o = tmo_master_q;
    assign timeout_count_o  = tmo_count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus for wb_arbiter (2 masters, 4-cycle watchdog)
// checked every cycle against a transaction-level model of ownership.
module tb_wb_arbiter;

    localparam int MN = 2;
    localparam int TO = 4;
    localparam int GW = $clog2(MN);

    logic          clk = 1'b0;
    logic          rst;
    logic [MN-1:0] m_cyc;
    logic [MN-1:0] m_stb;
    logic          s_ack;
    logic          s_err;
    logic          s_cyc_o;
    logic          s_stb_o;
    logic [MN-1:0] m_ack_o;
    logic [MN-1:0] m_err_o;
    logic [GW-1:0] grant_o;
    logic          grant_valid_o;
    logic          timeout_o;
    logic [GW-1:0] timeout_master_o;
    logic [7:0]    timeout_count_o;

    int tests = 0;
    int fails = 0;

    wb_arbiter #(.MASTERS_NUM(MN), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .m_cyc_i         (m_cyc),
        .m_stb_i         (m_stb),
        .s_ack_i         (s_ack),
        .s_err_i         (s_err),
        .s_cyc_o         (s_cyc_o),
        .s_stb_o         (s_stb_o),
        .m_ack_o         (m_ack_o),
        .m_err_o         (m_err_o),
        .grant_o         (grant_o),
        .grant_valid_o   (grant_valid_o),
        .timeout_o       (timeout_o),
        .timeout_master_o(timeout_master_o),
        .timeout_count_o (timeout_count_o)
    );

    always #5 clk = ~clk;

    // Model of who owns the bus: owner<0 means free, silent counts unanswered
    // strobe cycles, abort_now marks the error-pulse cycle, aborted the wait for release.
    int owner      = -1;
    bit abort_now  = 1'b0;
    bit aborted    = 1'b0;
    int silent     = 0;
    int rr_next    = 0;
    int n_aborts   = 0;
    int last_abort = 0;

    // Advance the ownership model on every clock edge from the inputs seen in that cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      = -1;
            abort_now  = 1'b0;
            aborted    = 1'b0;
            silent     = 0;
            rr_next    = 0;
            n_aborts   = 0;
            last_abort = 0;
        end else if (owner < 0) begin
            for (int i = 0; i < MN; i++) begin
                if (owner < 0 && m_cyc[(rr_next + i) % MN]) owner = (rr_next + i) % MN;
            end
            silent    = 0;
            aborted   = 1'b0;
            abort_now = 1'b0;
        end else if (abort_now) begin
            abort_now  = 1'b0;
            aborted    = 1'b1;
            last_abort = owner;
            if (n_aborts < 255) n_aborts++;
        end else if (!m_cyc[owner]) begin
            rr_next = (owner + 1) % MN;
            owner   = -1;
            aborted = 1'b0;
        end else if (!aborted) begin
            if (m_stb[owner] && !s_ack && !s_err) begin
                silent++;
                if (silent == TO) begin
                    abort_now = 1'b1;
                    silent    = 0;
                end
            end else begin
                silent = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Mid-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : compare
        logic          live;
        logic [MN-1:0] e_ack;
        logic [MN-1:0] e_err;
        if (!rst) begin
            live  = (owner >= 0) && !aborted && !abort_now;
            e_ack = '0;
            e_err = '0;
            if (live && m_stb[owner] && s_ack) e_ack[owner] = 1'b1;
            if (live && m_stb[owner] && s_err) e_err[owner] = 1'b1;
            if (abort_now) e_err[owner] = 1'b1;
            checkOutput("model_gv", 32'(grant_valid_o), 32'(owner >= 0));
            if (owner >= 0) checkOutput("model_grant", 32'(grant_o), 32'(owner));
            checkOutput("model_s_cyc", 32'(s_cyc_o), 32'(live && m_cyc[owner]));
            checkOutput("model_s_stb", 32'(s_stb_o), 32'(live && m_stb[owner]));
            checkOutput("model_m_ack", 32'(m_ack_o), 32'(e_ack));
            checkOutput("model_m_err", 32'(m_err_o), 32'(e_err));
            checkOutput("model_timeout", 32'(timeout_o), 32'(abort_now));
            checkOutput("model_tmo_master", 32'(timeout_master_o), 32'(last_abort));
            checkOutput("model_tmo_count", 32'(timeout_count_o), 32'(n_aborts));
        end
    end

    // Drive one cycle's inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic [MN-1:0] cyc, input logic [MN-1:0] stb,
                                 input logic ack, input logic err);
        m_cyc = cyc;
        m_stb = stb;
        s_ack = ack;
        s_err = err;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [MN-1:0] cyc, input logic [MN-1:0] stb,
                        input logic ack, input logic err);
        applyStimulus(cyc, stb, ack, err);
        tick();
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        logic [MN-1:0] bit_o;
        rst   = 1'b1;
        m_cyc = '0;
        m_stb = '0;
        s_ack = 1'b0;
        s_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        checkOutput("reset_gv", 32'(grant_valid_o), 32'd0);
        checkOutput("reset_grant", 32'(grant_o), 32'd0);
        checkOutput("reset_count", 32'(timeout_count_o), 32'd0);
        tick();

        // Async reset in the middle of an owned transfer.
        step(2'b01, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
        checkOutput("pre_rst_gv", 32'(grant_valid_o), 32'd1);
        checkOutput("pre_rst_s_stb", 32'(s_stb_o), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_gv", 32'(grant_valid_o), 32'd0);
        checkOutput("async_rst_s_cyc", 32'(s_cyc_o), 32'd0);
        checkOutput("async_rst_s_stb", 32'(s_stb_o), 32'd0);
        checkOutput("async_rst_grant", 32'(grant_o), 32'd0);
        tick();
        rst = 1'b0;

        // Round-robin with both masters requesting: 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            bit_o = (k % 2 == 0) ? 2'b01 : 2'b10;
            applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
            checkOutput("rr_idle_gap", 32'(grant_valid_o), 32'd0);
            tick();
            applyStimulus(2'b11, bit_o, 1'b0, 1'b0);
            checkOutput("rr_grant", 32'(grant_o), 32'(k % 2));
            checkOutput("rr_gv", 32'(grant_valid_o), 32'd1);
            tick();
            applyStimulus(2'b11, bit_o, 1'b1, 1'b0);
            checkOutput("rr_ack", 32'(m_ack_o), 32'(bit_o));
            tick();
            step(2'b11 & ~bit_o, 2'b00, 1'b0, 1'b0);
        end

        // Single requester (master 1), three transfers.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
            checkOutput("single_idle", 32'(grant_valid_o), 32'd0);
            tick();
            applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
            checkOutput("single_grant", 32'(grant_o), 32'd1);
            checkOutput("single_gv", 32'(grant_valid_o), 32'd1);
            tick();
            applyStimulus(2'b10, 2'b10, 1'b1, 1'b0);
            checkOutput("single_ack", 32'(m_ack_o), 32'b10);
            tick();
            step(2'b00, 2'b00, 1'b0, 1'b0);
        end

        // Watchdog abort on master 0 with a silent slave.
        step(2'b01, 2'b00, 1'b0, 1'b0);
        for (int c = 0; c < TO; c++) begin
            applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
            checkOutput("tmo_pre_stb", 32'(s_stb_o), 32'd1);
            checkOutput("tmo_pre_pulse", 32'(timeout_o), 32'd0);
            tick();
        end
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
        checkOutput("tmo_err", 32'(m_err_o), 32'b01);
        checkOutput("tmo_pulse", 32'(timeout_o), 32'd1);
        checkOutput("tmo_s_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(2'b01, 2'b01, 1'b1, 1'b0);
            checkOutput("tmo_late_ack", 32'(m_ack_o), 32'd0);
            checkOutput("tmo_count", 32'(timeout_count_o), 32'd1);
            checkOutput("tmo_master", 32'(timeout_master_o), 32'd0);
            checkOutput("tmo_hold_gv", 32'(grant_valid_o), 32'd1);
            tick();
        end
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        checkOutput("tmo_release_gv", 32'(grant_valid_o), 32'd1);
        tick();
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        checkOutput("tmo_idle_gv", 32'(grant_valid_o), 32'd0);
        tick();

        // Response in the limit cycle wins; back-to-back transfers restart the timer.
        step(2'b01, 2'b00, 1'b0, 1'b0);
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < TO - 1; c++) step(2'b01, 2'b01, 1'b0, 1'b0);
            applyStimulus(2'b01, 2'b01, (t == 0), (t == 1));
            checkOutput("race_ack", 32'(m_ack_o), (t == 0) ? 32'b01 : 32'b00);
            checkOutput("race_err", 32'(m_err_o), (t == 1) ? 32'b01 : 32'b00);
            tick();
            applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
            checkOutput("race_no_abort", 32'(timeout_o), 32'd0);
            checkOutput("race_still_owner", 32'(s_cyc_o), 32'd1);
            checkOutput("race_count", 32'(timeout_count_o), 32'd1);
            tick();
        end
        step(2'b00, 2'b00, 1'b0, 1'b0);

        // Saturate the abort counter with master 1.
        for (int n = 0; n < 260; n++) begin
            step(2'b10, 2'b00, 1'b0, 1'b0);
            for (int c = 0; c < TO; c++) step(2'b10, 2'b10, 1'b0, 1'b0);
            step(2'b10, 2'b10, 1'b0, 1'b0);
            applyStimulus(2'b10, 2'b10, 1'b1, 1'b0);
            checkOutput("sat_late_ack", 32'(m_ack_o), 32'd0);
            tick();
            step(2'b00, 2'b00, 1'b0, 1'b0);
        end
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        checkOutput("sat_count", 32'(timeout_count_o), 32'd255);
        checkOutput("sat_master", 32'(timeout_master_o), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
